// File: rtl/step_counter_pkg.sv
// rtl/step_counter_pkg.sv - shared mode and state encodings for the step counter
// Purpose: mode encodings for cfg_mode and the per-channel RUN/DONE state type.
// Ports: none (package).
package step_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_MODULO  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/step_counter_ch.sv
// rtl/step_counter_ch.sv - one step accumulator channel with mode mux and saturating adder
// Purpose: holds counter, step, max, mode and the RUN/DONE state of one channel.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   cnt        advance request for this channel
//   clr        synchronous clear of counter and state
//   cfg_we     config write for this channel (also clears counter/state)
//   cfg_step   new step, cfg_max new max, cfg_mode new mode
//   ov         combinational counter >= max
//   done       channel is in ONESHOT DONE state
module step_counter_ch
  import step_counter_pkg::*;
#(
  parameter int W            = 11,
  parameter int S            = 6,
  parameter int DEFAULT_STEP = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnt,
  input  logic         clr,
  input  logic         cfg_we,
  input  logic [S-1:0] cfg_step,
  input  logic [W-1:0] cfg_max,
  input  logic [1:0]   cfg_mode,
  output logic         ov,
  output logic         done
);

  logic [W-1:0] counter;
  logic [W-1:0] max_r;
  logic [S-1:0] step;
  logic [1:0]   mode;
  state_e       state;

  logic [W-1:0] base;
  logic [W:0]   inc;
  logic [W:0]   sum;
  logic [W-1:0] next_sat;

  assign ov   = (counter >= max_r);
  assign done = (state == ST_DONE);

  // Base value the increment is added to; ONESHOT only reaches the adder
  // while ov is low, so it shares the WRAP branch.
  always_comb begin
    inc      = cnt ? (W+1)'(step) : '0;
    base     = counter;
    if (mode == MODE_MODULO) begin
      base = ov ? (counter - max_r) : counter;
    end else begin
      base = ov ? '0 : counter;
    end
    sum      = {1'b0, base} + inc;
    next_sat = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      step    <= S'(DEFAULT_STEP);
      max_r   <= '1;
      mode    <= MODE_WRAP;
      state   <= ST_RUN;
    end else if (cfg_we) begin
      // A config write wins over clr and cnt and restarts the channel.
      step    <= cfg_step;
      max_r   <= cfg_max;
      mode    <= cfg_mode;
      counter <= '0;
      state   <= ST_RUN;
    end else if (clr) begin
      counter <= '0;
      state   <= ST_RUN;
    end else if (mode == MODE_ONESHOT) begin
      // Reaching max freezes the counter; DONE ignores cnt until cleared.
      if (state == ST_RUN) begin
        if (ov) begin
          state <= ST_DONE;
        end else begin
          counter <= next_sat;
        end
      end
    end else begin
      counter <= next_sat;
    end
  end

endmodule

// File: rtl/step_counter_mc.sv
// rtl/step_counter_mc.sv - multi-channel programmable step accumulator
// Purpose: NUM_CH independent step counters with per-channel config, clear and flags.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   cnt, clr   per-channel advance request and synchronous clear
//   cfg_we     config write strobe for channel cfg_ch
//   cfg_step, cfg_max, cfg_mode   config payload
//   ov         per-channel counter >= max (combinational)
//   done       per-channel ONESHOT DONE flag
//   ov_any     OR of ov
module step_counter_mc
  import step_counter_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 11,
  parameter int STEP_WIDTH    = 6,
  parameter int DEFAULT_STEP  = 6,
  parameter int CH_IDX_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        cnt,
  input  logic [NUM_CH-1:0]        clr,
  input  logic                     cfg_we,
  input  logic [CH_IDX_W-1:0]      cfg_ch,
  input  logic [STEP_WIDTH-1:0]    cfg_step,
  input  logic [COUNTER_WIDTH-1:0] cfg_max,
  input  logic [1:0]               cfg_mode,
  output logic [NUM_CH-1:0]        ov,
  output logic [NUM_CH-1:0]        done,
  output logic                     ov_any
);

  logic [NUM_CH-1:0] cfg_sel;

  // Channel indices with no matching channel select nothing, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_sel[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));

    step_counter_ch #(
      .W            (COUNTER_WIDTH),
      .S            (STEP_WIDTH),
      .DEFAULT_STEP (DEFAULT_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt[i]),
      .clr      (clr[i]),
      .cfg_we   (cfg_sel[i]),
      .cfg_step (cfg_step),
      .cfg_max  (cfg_max),
      .cfg_mode (cfg_mode),
      .ov       (ov[i]),
      .done     (done[i])
    );
  end

  assign ov_any = |ov;

endmodule

// File: tb/tb_step_counter_mc.sv
// tb/tb_step_counter_mc.sv - scoreboard bench for step_counter_mc
module tb_step_counter_mc;

  localparam int N    = 4;
  localparam int CMAX = 2047;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cnt = '0;
  logic [N-1:0] clr = '0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [5:0]   cfg_step = '0;
  logic [10:0]  cfg_max = '0;
  logic [1:0]   cfg_mode = '0;
  logic [N-1:0] ov;
  logic [N-1:0] done;
  logic         ov_any;

  step_counter_mc dut (
    .clk(clk), .rst(rst), .cnt(cnt), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_step(cfg_step), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
    .ov(ov), .done(done), .ov_any(ov_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ov;
    logic [N-1:0] done;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: plain integers per channel.
  int m_cnt[N];
  int m_step[N];
  int m_max[N];
  int m_mode[N];
  bit m_done[N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_step[i] = 6; m_max[i] = CMAX; m_mode[i] = 0; m_done[i] = 0;
    end
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // One clock of stimulus: drive, advance the model, push what the outputs must show after the edge.
  task automatic drive(input logic [N-1:0] c, input logic [N-1:0] k, input bit we,
                       input int ch, input int st, input int mx, input int md);
    exp_t e;
    @(negedge clk);
    cnt = c; clr = k; cfg_we = we; cfg_ch = 2'(ch);
    cfg_step = 6'(st); cfg_max = 11'(mx); cfg_mode = 2'(md);
    for (int i = 0; i < N; i++) begin
      bit was_ov;
      int inc;
      was_ov = (m_cnt[i] >= m_max[i]);
      inc    = c[i] ? m_step[i] : 0;
      if (we && ch == i) begin
        m_step[i] = st; m_max[i] = mx; m_mode[i] = md; m_cnt[i] = 0; m_done[i] = 0;
      end else if (k[i]) begin
        m_cnt[i] = 0; m_done[i] = 0;
      end else if (m_mode[i] == 2) begin
        if (!m_done[i]) begin
          if (was_ov) m_done[i] = 1;
          else m_cnt[i] = sat(m_cnt[i] + inc);
        end
      end else if (m_mode[i] == 1) begin
        m_cnt[i] = sat((was_ov ? m_cnt[i] - m_max[i] : m_cnt[i]) + inc);
      end else begin
        m_cnt[i] = sat((was_ov ? 0 : m_cnt[i]) + inc);
      end
      e.ov[i]   = (m_cnt[i] >= m_max[i]);
      e.done[i] = m_done[i];
    end
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: the DUT presents fresh flags every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ov", ov, e.ov);
        check("done", done, e.done);
        check("ov_any", {{(N-1){1'b0}}, ov_any}, {{(N-1){1'b0}}, |e.ov});
      end
    end
  end

  initial begin
    model_reset();
    #23;
    check("reset_ov", ov, '0);
    check("reset_done", done, '0);
    check("reset_ov_any", {{(N-1){1'b0}}, ov_any}, '0);
    @(negedge clk);
    rst = 1'b0;

    // WRAP ch0 step 6 max 20
    drive('0, '0, 1, 0, 6, 20, 0);
    for (int t = 0; t < 10; t++) drive(4'b0001, '0, 0, 0, 0, 0, 0);
    // MODULO ch1 step 6 max 20
    drive('0, '0, 1, 1, 6, 20, 1);
    for (int t = 0; t < 12; t++) drive(4'b0010, '0, 0, 0, 0, 0, 0);
    // ONESHOT ch2 step 5 max 10, clr then resume
    drive('0, '0, 1, 2, 5, 10, 2);
    for (int t = 0; t < 6; t++) drive(4'b0100, '0, 0, 0, 0, 0, 0);
    drive(4'b0100, 4'b0100, 0, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) drive(4'b0100, '0, 0, 0, 0, 0, 0);
    // WRAP ch3 step 63 max 2047: saturation path
    drive('0, '0, 1, 3, 63, 2047, 0);
    for (int t = 0; t < 36; t++) drive(4'b1000, '0, 0, 0, 0, 0, 0);
    // Independence: cfg ch1 while ch0 counts, then clr+cnt on ch0
    for (int t = 0; t < 3; t++) drive(4'b0011, '0, 0, 0, 0, 0, 0);
    drive(4'b0011, '0, 1, 1, 7, 30, 0);
    for (int t = 0; t < 3; t++) drive(4'b0011, '0, 0, 0, 0, 0, 0);
    drive(4'b0001, 4'b0001, 0, 0, 0, 0, 0);
    // cfg_we plus clr on the same channel
    drive(4'b0010, 4'b0010, 1, 1, 3, 9, 1);
    // max=0 in each mode
    drive('0, '0, 1, 0, 5, 0, 0);
    drive('0, '0, 1, 1, 5, 0, 1);
    drive('0, '0, 1, 2, 5, 0, 2);
    for (int t = 0; t < 4; t++) drive(4'b0111, '0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      int mx;
      bit we;
      we = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0: mx = 0;
        1: mx = $urandom_range(2000, 2047);
        default: mx = $urandom_range(1, 40);
      endcase
      drive(4'($urandom), ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0, we,
            $urandom_range(0, 3), $urandom_range(0, 63), mx, $urandom_range(0, 3));
    end

    // Async reset mid-cycle with flags high
    drive('0, '0, 1, 2, 5, 0, 2);
    drive('0, '0, 0, 0, 0, 0, 0);
    drive('0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_ov", ov, '0);
    check("async_done", done, '0);
    check("async_ov_any", {{(N-1){1'b0}}, ov_any}, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Reset config: step 6 max 2047 WRAP on every channel
    for (int t = 0; t < 345; t++) drive(4'b1111, '0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
